// File: rtl/display_pkg.sv
// +--------------------------------------------------------------------------+
// | display_pkg : types and helpers shared by the display front-end blocks   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

package display_pkg;

    localparam int BCD_MAX = 9999;

    typedef logic [3:0] bcd_t;
    typedef logic [1:0] digit_sel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] acc);
        logic [15:0] res;
        res = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_counter.sv
// +--------------------------------------------------------------------------+
// | scan_counter : prescaled free-running 2-bit digit-select scan            |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module scan_counter
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [1:0] digit
);

    localparam int                 c_PW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PW-1:0]    c_TERM = c_PW'(SCAN_DIV - 1);

    logic [c_PW-1:0] r_presc;
    digit_sel_t      r_digit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_digit <= '0;
        end else if (r_presc == c_TERM) begin
            r_presc <= '0;
            r_digit <= r_digit + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign digit = r_digit;

endmodule

`default_nettype wire

// File: rtl/bcd_scanner.sv
// +--------------------------------------------------------------------------+
// | bcd_scanner : iterative binary-to-BCD converter plus digit scan source   |
// | Optional macro BCD_SCAN_OVF_EN adds the ovf output (raw value > 9999).   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module bcd_scanner
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int IN_W     = 14
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [IN_W-1:0] value,
    input  logic            load,
    output logic            busy,
    output logic            done,
    output logic [3:0]      num3,
    output logic [3:0]      num2,
    output logic [3:0]      num1,
    output logic [3:0]      num0,
    output logic [1:0]      digit
`ifdef BCD_SCAN_OVF_EN
    ,
    output logic            ovf
`endif
);

    localparam logic [IN_W-1:0] c_MAX   = IN_W'(BCD_MAX);
    localparam logic [3:0]      c_STEPS = 4'(IN_W);

    state_t          r_state;
    logic [IN_W-1:0] r_bin;
    logic [15:0]     r_acc;
    logic [3:0]      r_step;
    logic            r_busy;
    logic            r_done;
    logic [15:0]     r_num;

    logic [IN_W-1:0] w_clamped;
    logic [15:0]     w_adj;
    logic            w_accept;

    assign w_clamped = (value > c_MAX) ? c_MAX : value;
    assign w_adj     = bcd_adjust(r_acc);
    assign w_accept  = (r_state == IDLE) && load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_acc   <= '0;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_num   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_bin   <= w_clamped;
                        r_acc   <= '0;
                        r_step  <= c_STEPS;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {r_acc, r_bin} <= {w_adj, r_bin} << 1;
                    r_step         <= r_step - 4'd1;
                    if (r_step == 4'd1) begin
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    // Digits only change here, so no partial result is ever visible.
                    r_num   <= r_acc;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef BCD_SCAN_OVF_EN
    logic r_ovf_raw;
    logic r_ovf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_raw <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ovf_raw <= (value > c_MAX);
            end
            if (r_state == UPDATE) begin
                r_ovf <= r_ovf_raw;
            end
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign num3 = r_num[15:12];
    assign num2 = r_num[11:8];
    assign num1 = r_num[7:4];
    assign num0 = r_num[3:0];

    scan_counter #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .digit   (digit)
    );

endmodule

`default_nettype wire

// File: tb/tb_bcd_scanner.sv
// +--------------------------------------------------------------------------+
// | tb_bcd_scanner : self-checking bench for bcd_scanner (SCAN_DIV = 4)      |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_bcd_scanner;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load;
    logic [13:0] value;
    logic        busy;
    logic        done;
    logic [3:0]  num3, num2, num1, num0;
    logic [1:0]  digit;
`ifdef BCD_SCAN_OVF_EN
    logic        ovf;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [15:0] exp_num  = 16'h0000;
    logic        exp_ovf  = 1'b0;

    always #5 clk = ~clk;

    bcd_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .IN_W     (14)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .value   (value),
        .load    (load),
        .busy    (busy),
        .done    (done),
        .num3    (num3),
        .num2    (num2),
        .num1    (num1),
        .num0    (num0),
        .digit   (digit)
`ifdef BCD_SCAN_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    // Reference: decimal digits of the clamped value by plain arithmetic.
    function automatic logic [15:0] ref_bcd(input int v);
        int c;
        c = (v > 9999) ? 9999 : v;
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic exp_busy, input logic exp_done);
        chk({tag, "_num"},  32'({num3, num2, num1, num0}), 32'(exp_num));
        chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
`ifdef BCD_SCAN_OVF_EN
        chk({tag, "_ovf"},  32'(ovf), 32'(exp_ovf));
`endif
    endtask

    // One clock; the scan is checked on every cycle against elapsed time.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        chk("digit", 32'(digit), 32'((cyc / SCAN_DIV) % 4));
    endtask

    task automatic convert(input int v);
        value = 14'(v);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        value = 14'($urandom_range(0, 16383));
        chk_state("accept", 1'b1, 1'b0);
        repeat (14) begin
            tick();
            chk_state("shift", 1'b1, 1'b0);
        end
        tick();
        exp_num = ref_bcd(v);
        exp_ovf = (v > 9999);
        chk_state("result", 1'b0, 1'b1);
        tick();
        chk_state("after", 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        load    = 1'b0;
        value   = '0;
        #12;
        chk("rst_digit", 32'(digit), 32'd0);
        chk_state("rst", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc     = 0;

        convert(1234);
        convert(0);
        convert(9999);
        convert(16383);
        convert(10000);

        // Busy lockout: loads at +5 and +15 are ignored, +16 is accepted.
        value = 14'd4321;
        load  = 1'b1;
        tick();
        for (int k = 1; k <= 15; k++) begin
            load  = (k == 5 || k == 15);
            value = 14'd1111;
            tick();
            if (k < 15) begin
                chk_state("lock_busy", 1'b1, 1'b0);
            end else begin
                exp_num = ref_bcd(4321);
                exp_ovf = 1'b0;
                chk_state("lock_res", 1'b0, 1'b1);
            end
        end
        load = 1'b0;
        convert(1111);

        repeat (10) begin
            convert(int'($urandom_range(0, 16383)));
        end

        // Reset mid-conversion aborts with no done pulse.
        value = 14'd5678;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        exp_num = 16'h0000;
        exp_ovf = 1'b0;
        chk("midrst_digit", 32'(digit), 32'd0);
        chk_state("midrst", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc     = 0;
        repeat (20) begin
            tick();
            chk_state("post_rst", 1'b0, 1'b0);
        end

        convert(8765);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
